// File: rtl/mips_cpu_bus_lsu.sv
// rtl/mips_cpu_bus_lsu.sv - Avalon bus access unit for the multicycle MIPS core
// Serialises fetch/load/store requests onto one Avalon master with sub-word support.
module mips_cpu_bus_lsu #(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        resp_halt,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [3:0] OP_LW = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6;
    localparam logic [3:0] OP_SW = 4'd8, OP_SB = 4'd9, OP_SH = 4'd10, OP_FETCH = 4'd15;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rt_old_q, rt_old_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d, write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, resp_halt_q, resp_halt_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        accept, legal, misaligned, is_store;

    function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] k,
                                                input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = m[8*k +: 8];
        h = m[16*k[1] +: 16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            // Shifts of 32 yield zero, so k=3 (LWL) and k=0 (LWR) fall out as plain m.
            OP_LWL:  r = (m << (8 * (3 - int'(k)))) | (rt & (32'hFFFF_FFFF >> (8 * (int'(k) + 1))));
            OP_LWR:  r = (m >> (8 * int'(k))) | (rt & ~(32'hFFFF_FFFF >> (8 * int'(k))));
            default: r = m;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [3:0] op, input logic [1:0] k);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << k;
            OP_LH, OP_LHU, OP_SH: return k[1] ? 4'b1100 : 4'b0011;
            default:              return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] w);
        case (op)
            OP_SB:   return {4{w[7:0]}};
            OP_SH:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign is_store  = (req_op == OP_SW) || (req_op == OP_SB) || (req_op == OP_SH);

    always_comb begin
        legal      = 1'b1;
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW, OP_FETCH:              misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:                misaligned = req_addr[0];
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: misaligned = 1'b0;
            default:                             legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        k_d          = k_q;
        rt_old_d     = rt_old_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_halt_d  = resp_halt_q;
        resp_data_d  = resp_data_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d     = req_op;
                k_d      = req_addr[1:0];
                rt_old_d = req_rt_old;
                if (!legal || misaligned || (req_op == OP_FETCH && req_addr == HALT_ADDR)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !legal || misaligned;
                    resp_halt_d  = legal && !misaligned;
                    resp_data_d  = 32'd0;
                end else begin
                    state_d      = S_BUS;
                    address_d    = {req_addr[31:2], 2'b00};
                    read_d       = !is_store;
                    write_d      = is_store;
                    byteenable_d = lane_mask(req_op, req_addr[1:0]);
                    writedata_d  = store_data(req_op, req_wdata);
                    wait_cnt_d   = 32'd0;
                end
            end
            S_BUS: begin
                if (!waitrequest) begin
                    state_d      = S_RESP;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = write_q ? 32'd0 : load_result(op_q, k_q, readdata, rt_old_q);
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == TO_LAST) begin
                    state_d      = S_RESP;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_halt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            k_q          <= 2'd0;
            rt_old_q     <= 32'd0;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_halt_q  <= 1'b0;
            resp_data_q  <= 32'd0;
            wait_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            k_q          <= k_d;
            rt_old_q     <= rt_old_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_halt_q  <= resp_halt_d;
            resp_data_q  <= resp_data_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_halt  = resp_halt_q;
    assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// tb/tb_mips_cpu_bus_lsu.sv - directed and randomized bench for mips_cpu_bus_lsu
// The reference model works on a byte-addressed memory rather than lane arithmetic.
module tb_mips_cpu_bus_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt_old;
    logic        resp_valid, resp_err, resp_halt;
    logic [31:0] resp_data, address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    mips_cpu_bus_lsu #(.HALT_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_halt(resp_halt),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rt, output bit bus, output bit st, output bit err,
                         output bit halt, output logic [31:0] data, output logic [3:0] be,
                         output logic [31:0] wdo);
        int size, k;
        bit legal, full, mis;
        logic [31:0] base;
        logic [7:0] b;
        logic [15:0] h;
        base = a & ~32'd3;
        k = int'(a[1:0]);
        legal = 1; st = 0; full = 0; size = 4; data = 32'd0;
        b = rd_byte(a);
        h = {rd_byte(a + 1), rd_byte(a)};
        case (op)
            4'd0:  data = rd_word(base);
            4'd1:  begin size = 1; data = 32'($signed(b)); end
            4'd2:  begin size = 1; data = {24'd0, b}; end
            4'd3:  begin size = 2; data = 32'($signed(h)); end
            4'd4:  begin size = 2; data = {16'd0, h}; end
            4'd5:  begin
                full = 1;
                for (int i = 0; i < 4; i++)
                    data[8*i +: 8] = (i >= 3 - k) ? rd_byte(base + 32'(i - (3 - k))) : rt[8*i +: 8];
            end
            4'd6:  begin
                full = 1;
                for (int i = 0; i < 4; i++)
                    data[8*i +: 8] = (i <= 3 - k) ? rd_byte(base + 32'(i + k)) : rt[8*i +: 8];
            end
            4'd8:  st = 1;
            4'd9:  begin size = 1; st = 1; end
            4'd10: begin size = 2; st = 1; end
            4'd15: data = rd_word(base);
            default: legal = 0;
        endcase
        mis  = legal && !full && (k % size != 0);
        err  = !legal || mis;
        halt = legal && !mis && op == 4'd15 && a == 32'd0;
        bus  = !err && !halt;
        be   = (full || size == 4) ? 4'b1111 : (size == 2) ? (4'b0011 << k) : (4'b0001 << k);
        wdo  = (size == 4) ? wd : (size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
        if (!bus || st) data = 32'd0;
    endtask

    task automatic noise();
        req_valid  = 1'($urandom_range(0, 1));
        req_op     = 4'd0;
        req_addr   = $urandom & ~32'd3;
        req_wdata  = $urandom;
        req_rt_old = $urandom;
    endtask

    // Entered and left at a negedge with the unit idle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rt, input int nwait,
                          output logic [31:0] got);
        bit bus, st, err, halt, tmo;
        logic [31:0] data, wdo, base;
        logic [3:0] be;
        int ncyc;
        model(op, a, wd, rt, bus, st, err, halt, data, be, wdo);
        base = a & ~32'd3;
        tmo = bus && (nwait >= TO);
        if (tmo) begin err = 1; data = 32'd0; end
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_rt_old = rt;
        @(posedge clk);
        @(negedge clk);
        noise();
        if (bus) begin
            ncyc = tmo ? TO : nwait + 1;
            for (int c = 0; c < ncyc; c++) begin
                check({tag, ":read"}, 32'(read), 32'(!st));
                check({tag, ":write"}, 32'(write), 32'(st));
                check({tag, ":addr"}, address, base);
                check({tag, ":be"}, 32'(byteenable), 32'(be));
                if (st) check({tag, ":wdata"}, writedata, wdo);
                check({tag, ":busy_resp"}, 32'(resp_valid), 32'd0);
                waitrequest = (c < nwait);
                readdata = (c < nwait) ? $urandom : rd_word(base);
                @(posedge clk);
                @(negedge clk);
                noise();
            end
        end
        check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ":resp_err"}, 32'(resp_err), 32'(err));
        check({tag, ":resp_halt"}, 32'(resp_halt), 32'(halt));
        check({tag, ":resp_data"}, resp_data, data);
        check({tag, ":resp_rw"}, {30'd0, read, write}, 32'd0);
        check({tag, ":resp_ready"}, 32'(req_ready), 32'd0);
        got = resp_data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waitrequest = 1'b0;
        check({tag, ":idle"}, {29'd0, resp_valid, read, write}, 32'd0);
        check({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
        if (st && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[base + 32'(i)] = wdo[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [3:0] rop;
        logic [31:0] raddr;
        int rw;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        req_rt_old = 32'd0; waitrequest = 1'b0; readdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:ready", 32'(req_ready), 32'd0);
        check("rst:flags", {27'd0, resp_valid, resp_err, resp_halt, read, write}, 32'd0);
        check("rst:address", address, 32'd0);
        check("rst:writedata", writedata, 32'd0);
        check("rst:be", 32'(byteenable), 32'd0);
        check("rst:resp_data", resp_data, 32'd0);
        rst = 1'b0;
        #1;
        check("rst:ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);

        set_word(32'h1000, 32'hDEAD_BEEF);
        run_op("lw", 4'd0, 32'h1000, 32'd0, 32'd0, 0, got);
        check("lw:lit", got, 32'hDEAD_BEEF);
        set_word(32'h1000, 32'h80FF_1234);
        run_op("lb", 4'd1, 32'h1003, 32'd0, 32'd0, 0, got);
        check("lb:lit", got, 32'hFFFF_FF80);
        run_op("lbu", 4'd2, 32'h1003, 32'd0, 32'd0, 1, got);
        check("lbu:lit", got, 32'h0000_0080);
        run_op("sh", 4'd10, 32'h2002, 32'h0000_ABCD, 32'd0, 3, got);
        run_op("lw_after_sh", 4'd0, 32'h2000, 32'd0, 32'd0, 0, got);
        check("sh:lit", {16'd0, got[31:16]}, 32'h0000_ABCD);
        set_word(32'h3000, 32'h4433_2211);
        run_op("lwl", 4'd5, 32'h3001, $urandom, 32'hAABB_CCDD, 0, got);
        check("lwl:lit", got, 32'h2211_CCDD);
        run_op("lwr", 4'd6, 32'h3001, $urandom, 32'hAABB_CCDD, 2, got);
        check("lwr:lit", got, 32'hAA44_3322);
        run_op("lw_mis", 4'd0, 32'h1002, 32'd0, 32'd0, 0, got);
        run_op("lh_mis", 4'd3, 32'h1001, 32'd0, 32'd0, 0, got);
        run_op("fetch_halt", 4'd15, 32'h0, 32'd0, 32'd0, 0, got);
        run_op("illegal", 4'd7, 32'h1000, 32'd0, 32'd0, 0, got);
        run_op("timeout", 4'd0, 32'h1000, 32'd0, 32'd0, 50, got);
        run_op("timeout_sw", 4'd8, 32'h1000, 32'h1111_2222, 32'd0, TO, got);
        run_op("wait_max", 4'd15, 32'h1000, 32'd0, 32'd0, TO - 1, got);

        // Reset in the middle of a bus cycle must abandon the response.
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h1000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; waitrequest = 1'b1;
        check("rstbus:read", 32'(read), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstbus:read_drop", 32'(read), 32'd0);
        check("rstbus:no_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0; waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstbus:quiet", {30'd0, resp_valid, read}, 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            raddr = 32'h100 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) raddr = 32'd0;
            rw = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 2);
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, raddr, $urandom, $urandom, rw, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
